// File: rtl/per2axi_req_arbiter.sv
// per2axi_req_arbiter
//   Shares one per2axi bridge port between NB_REQ peripheral requesters.
//   Round-robin arbitration, one-hot ID tag per granted request, responses
//   routed back by ID bit, per-requester outstanding limit and a registered
//   aggregate busy flag.
//
//   Optional macro PER2AXI_ARB_ATOP_SERIALIZE_EN: when defined, a granted
//   atomic (atop != 0) blocks all arbitration until the response for its
//   owner returns. When undefined, atomics arbitrate like plain requests.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/add_i/wen_i/wdata_i/be_i/atop_i   per-requester request fields
//   gnt_o                per-requester grant (zero-cycle)
//   r_valid_o            per-requester response valid
//   r_opc_o, r_rdata_o   response error flag / data, broadcast
//   per_*_o              request to bridge, per_id_o = one-hot winner
//   per_gnt_i            bridge grant
//   per_r_valid_i/per_r_id_i/per_r_opc_i/per_r_rdata_i   bridge response
//   busy_o               any request outstanding (registered)
module per2axi_req_arbiter #(
   parameter int unsigned NB_REQ         = 4,
   parameter int unsigned PER_ADDR_WIDTH = 32,
   parameter int unsigned PER_DATA_WIDTH = 32,
   parameter int unsigned PER_ID_WIDTH   = 5,
   parameter int unsigned MAX_OUTST      = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NB_REQ-1:0]                           req_i,
   input  logic [NB_REQ-1:0][PER_ADDR_WIDTH-1:0]       add_i,
   input  logic [NB_REQ-1:0]                           wen_i,
   input  logic [NB_REQ-1:0][PER_DATA_WIDTH-1:0]       wdata_i,
   input  logic [NB_REQ-1:0][PER_DATA_WIDTH/8-1:0]     be_i,
   input  logic [NB_REQ-1:0][5:0]                      atop_i,
   output logic [NB_REQ-1:0]                           gnt_o,
   output logic [NB_REQ-1:0]                           r_valid_o,
   output logic                                        r_opc_o,
   output logic [PER_DATA_WIDTH-1:0]                   r_rdata_o,
   output logic                                        per_req_o,
   output logic [PER_ADDR_WIDTH-1:0]                   per_add_o,
   output logic                                        per_wen_o,
   output logic [PER_DATA_WIDTH-1:0]                   per_wdata_o,
   output logic [PER_DATA_WIDTH/8-1:0]                 per_be_o,
   output logic [5:0]                                  per_atop_o,
   output logic [PER_ID_WIDTH-1:0]                     per_id_o,
   input  logic                                        per_gnt_i,
   input  logic                                        per_r_valid_i,
   input  logic [PER_ID_WIDTH-1:0]                     per_r_id_i,
   input  logic                                        per_r_opc_i,
   input  logic [PER_DATA_WIDTH-1:0]                   per_r_rdata_i,
   output logic                                        busy_o
);

   localparam int unsigned PTR_W   = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTST);

   if (PER_ID_WIDTH < NB_REQ) begin : g_bad_id_width
      $error("PER_ID_WIDTH must be >= NB_REQ");
   end
   if (NB_REQ < 1 || NB_REQ > 16) begin : g_bad_nb_req
      $error("NB_REQ must be in 1..16");
   end
   if (MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_bad_max_outst
      $error("MAX_OUTST must be in 1..15");
   end

   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       win;
   logic                   any_elig;
   logic                   hs;
   logic                   blocked;
   logic [NB_REQ-1:0]      elig;
   logic [NB_REQ-1:0][3:0] cnt_q, cnt_d;
   logic [NB_REQ-1:0]      inc, dec;
   logic [NB_REQ-1:0]      cnt_nz;
   logic                   busy_d;

`ifdef PER2AXI_ARB_ATOP_SERIALIZE_EN
   typedef enum logic {ARB_OPEN, ARB_LOCKED} lock_state_e;
   lock_state_e      lock_q, lock_d;
   logic [PTR_W-1:0] lock_owner_q, lock_owner_d;

   assign blocked = (lock_q == ARB_LOCKED);

   // Set wins over clear: a new atomic handshaked in the same cycle as the
   // previous owner's response re-arms the lock for the new owner.
   always_comb begin
      lock_d       = lock_q;
      lock_owner_d = lock_owner_q;
      if (per_r_valid_i && per_r_id_i[lock_owner_q]) lock_d = ARB_OPEN;
      if (hs && (per_atop_o != '0)) begin
         lock_d       = ARB_LOCKED;
         lock_owner_d = win;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q       <= ARB_OPEN;
         lock_owner_q <= '0;
      end else begin
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
      end
   end
`else
   assign blocked = 1'b0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         elig[i] = req_i[i] && !blocked && (cnt_q[i] < MAX_CNT);
      end
   end

   // First eligible requester found scanning upward from rr_ptr, wrapping.
   always_comb begin
      int unsigned sum;
      win      = '0;
      any_elig = 1'b0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         sum = 32'(rr_ptr_q) + k;
         if (sum >= NB_REQ) sum = sum - NB_REQ;
         if (!any_elig && elig[PTR_W'(sum)]) begin
            any_elig = 1'b1;
            win      = PTR_W'(sum);
         end
      end
   end

   assign hs          = any_elig & per_gnt_i;
   assign per_req_o   = any_elig;
   assign per_add_o   = add_i[win];
   assign per_wen_o   = wen_i[win];
   assign per_wdata_o = wdata_i[win];
   assign per_be_o    = be_i[win];
   assign per_atop_o  = atop_i[win];

   always_comb begin
      per_id_o = '0;
      gnt_o    = '0;
      if (any_elig) begin
         per_id_o[win] = 1'b1;
         gnt_o[win]    = per_gnt_i;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) rr_ptr_d = (win == PTR_W'(NB_REQ - 1)) ? '0 : win + 1'b1;
   end

   assign r_valid_o = per_r_valid_i ? per_r_id_i[NB_REQ-1:0] : '0;
   assign r_opc_o   = per_r_opc_i;
   assign r_rdata_o = per_r_rdata_i;

   // Decrement is suppressed on an empty counter so a spurious response
   // cannot wrap it; increment is evaluated independently of that.
   always_comb begin
      busy_d = 1'b0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         cnt_nz[i] = (cnt_q[i] != '0);
         inc[i]    = hs && (win == PTR_W'(i));
         dec[i]    = per_r_valid_i && per_r_id_i[i] && cnt_nz[i];
         cnt_d[i]  = cnt_q[i];
         if (inc[i] && !dec[i]) cnt_d[i] = cnt_q[i] + 4'd1;
         if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - 4'd1;
         if (cnt_d[i] != '0) busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         busy_o   <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         busy_o   <= busy_d;
      end
   end

`ifndef SYNTHESIS
   logic rsp_ok;
   assign rsp_ok = $onehot(per_r_id_i) && ((per_r_id_i[NB_REQ-1:0] & cnt_nz) != '0);

   spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  per_r_valid_i |-> rsp_ok)
      else $warning("per2axi_req_arbiter: response id %b with no matching outstanding request",
                    per_r_id_i);
`endif

endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// Testbench for per2axi_req_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model (per-requester outstanding
// counts, round-robin pointer, optional atomic lock).
module tb_per2axi_req_arbiter;

   localparam int NB = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 5;
   localparam int MO = 4;
   localparam int BW = DW / 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NB-1:0]          req;
   logic [NB-1:0][AW-1:0]  add;
   logic [NB-1:0]          wen;
   logic [NB-1:0][DW-1:0]  wdata;
   logic [NB-1:0][BW-1:0]  be;
   logic [NB-1:0][5:0]     atop;
   logic [NB-1:0]          gnt;
   logic [NB-1:0]          r_valid;
   logic                   r_opc;
   logic [DW-1:0]          r_rdata;
   logic                   per_req;
   logic [AW-1:0]          per_add;
   logic                   per_wen;
   logic [DW-1:0]          per_wdata;
   logic [BW-1:0]          per_be;
   logic [5:0]             per_atop;
   logic [IW-1:0]          per_id;
   logic                   per_gnt;
   logic                   per_r_valid;
   logic [IW-1:0]          per_r_id;
   logic                   per_r_opc;
   logic [DW-1:0]          per_r_rdata;
   logic                   busy;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int  m_cnt[NB];
   int  m_ptr;
   bit  m_busy;
   bit  m_lock;
   int  m_owner;

   // model outputs for the current input set
   bit            e_req;
   int            e_w;
   logic [NB-1:0] e_gnt;
   logic [IW-1:0] e_id;
   logic [NB-1:0] e_rv;

   always #5 clk = ~clk;

   per2axi_req_arbiter #(
      .NB_REQ(NB), .PER_ADDR_WIDTH(AW), .PER_DATA_WIDTH(DW),
      .PER_ID_WIDTH(IW), .MAX_OUTST(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be), .atop_i(atop),
      .gnt_o(gnt), .r_valid_o(r_valid), .r_opc_o(r_opc), .r_rdata_o(r_rdata),
      .per_req_o(per_req), .per_add_o(per_add), .per_wen_o(per_wen),
      .per_wdata_o(per_wdata), .per_be_o(per_be), .per_atop_o(per_atop),
      .per_id_o(per_id), .per_gnt_i(per_gnt),
      .per_r_valid_i(per_r_valid), .per_r_id_i(per_r_id),
      .per_r_opc_i(per_r_opc), .per_r_rdata_i(per_r_rdata),
      .busy_o(busy)
   );

   task automatic idle_inputs();
      req = '0; add = '0; wen = '0; wdata = '0; be = '0; atop = '0;
      per_gnt = 1'b0; per_r_valid = 1'b0; per_r_id = '0;
      per_r_opc = 1'b0; per_r_rdata = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      m_ptr = 0; m_busy = 0; m_lock = 0; m_owner = 0;
   endtask

   task automatic model_eval();
      e_req = 0; e_w = 0;
      for (int k = 0; k < NB; k++) begin
         int i;
         i = (m_ptr + k) % NB;
         if (!e_req && req[i] && m_cnt[i] < MO && !m_lock) begin
            e_req = 1; e_w = i;
         end
      end
      e_gnt = '0; e_id = '0;
      if (e_req) begin
         e_id[e_w] = 1'b1;
         if (per_gnt) e_gnt[e_w] = 1'b1;
      end
      e_rv = per_r_valid ? per_r_id[NB-1:0] : '0;
   endtask

   // Advance the model with the inputs currently applied, then one clock.
   task automatic tick();
      bit hs;
      model_eval();
      hs = e_req && per_gnt;
      for (int i = 0; i < NB; i++)
         if (per_r_valid && per_r_id[i] && m_cnt[i] > 0) m_cnt[i]--;
      if (hs) m_cnt[e_w]++;
`ifdef PER2AXI_ARB_ATOP_SERIALIZE_EN
      if (per_r_valid && m_lock && per_r_id[m_owner]) m_lock = 0;
      if (hs && atop[e_w] != 6'd0) begin m_lock = 1; m_owner = e_w; end
`endif
      if (hs) m_ptr = (e_w + 1) % NB;
      m_busy = 0;
      for (int i = 0; i < NB; i++) if (m_cnt[i] != 0) m_busy = 1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      #2;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
      n_vec++; if (per_req !== 1'b0) begin n_err++; $display("FAIL reset_per_req got %b exp 0", per_req); end
      n_vec++; if (r_valid !== 4'b0000) begin n_err++; $display("FAIL reset_r_valid got %b exp 0000", r_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_single_read();
      do_reset();
      req = 4'b0001; wen = 4'b0001; add[0] = 32'h1000_0000; per_gnt = 1'b1;
      #1;
      n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt got %b exp 0001", gnt); end
      n_vec++; if (per_id !== 5'b00001) begin n_err++; $display("FAIL single_id got %b exp 00001", per_id); end
      n_vec++; if (per_add !== 32'h1000_0000 || per_wen !== 1'b1) begin
         n_err++; $display("FAIL single_req_fields got add=%h wen=%b exp add=10000000 wen=1", per_add, per_wen); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_set got %b exp 1", busy); end
      per_r_valid = 1'b1; per_r_id = 5'b00001; per_r_rdata = 32'hDEAD_BEEF;
      #1;
      n_vec++; if (r_valid !== 4'b0001) begin n_err++; $display("FAIL single_r_valid got %b exp 0001", r_valid); end
      n_vec++; if (r_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_rdata got %h exp deadbeef", r_rdata); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hold got %b exp 1", busy); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear got %b exp 0", busy); end
   endtask

   task automatic test_round_robin();
      logic [NB-1:0] exp_seq [5];
      logic [NB-1:0] prev;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      prev = '0;
      do_reset();
      req = 4'b1111; wen = 4'b1111; per_gnt = 1'b1;
      for (int c = 0; c < 5; c++) begin
         per_r_valid = (prev != '0);
         per_r_id    = {1'b0, prev};
         #1;
         n_vec++; if (gnt !== exp_seq[c]) begin n_err++; $display("FAIL rr_gnt[%0d] got %b exp %b", c, gnt, exp_seq[c]); end
         n_vec++; if (per_id !== {1'b0, exp_seq[c]}) begin n_err++; $display("FAIL rr_id[%0d] got %b exp %b", c, per_id, {1'b0, exp_seq[c]}); end
         prev = exp_seq[c];
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_max_outst();
      do_reset();
      req = 4'b0100; per_gnt = 1'b1;
      for (int c = 0; c < MO; c++) begin
         #1;
         n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL outst_fill[%0d] got %b exp 0100", c, gnt); end
         tick();
      end
      req = 4'b0101;
      #1;
      n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL outst_other0 got %b exp 0001", gnt); end
      tick();
      #1;
      n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL outst_other1 got %b exp 0001", gnt); end
      tick();
      req = 4'b0100;
      #1;
      n_vec++; if (per_req !== 1'b0 || gnt !== 4'b0000) begin
         n_err++; $display("FAIL outst_blocked got req=%b gnt=%b exp req=0 gnt=0000", per_req, gnt); end
      per_gnt = 1'b0; per_r_valid = 1'b1; per_r_id = 5'b00100;
      #1;
      n_vec++; if (r_valid !== 4'b0100) begin n_err++; $display("FAIL outst_resp got %b exp 0100", r_valid); end
      tick();
      per_r_valid = 1'b0; per_r_id = '0; per_gnt = 1'b1;
      #1;
      n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL outst_regrant got %b exp 0100", gnt); end
      tick();
      idle_inputs();
   endtask

   task automatic test_same_cycle();
      do_reset();
      req = 4'b0010; per_gnt = 1'b1;
      #1; tick();
      #1; tick();
      per_r_valid = 1'b1; per_r_id = 5'b00010;
      #1;
      n_vec++; if (gnt !== 4'b0010 || r_valid !== 4'b0010) begin
         n_err++; $display("FAIL same_cycle got gnt=%b rv=%b exp gnt=0010 rv=0010", gnt, r_valid); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL same_cycle_busy got %b exp 1", busy); end
      per_r_valid = 1'b1; per_r_id = 5'b00010;
      #1; tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL same_cycle_cnt1 got busy=%b exp 1", busy); end
      per_r_valid = 1'b1; per_r_id = 5'b00010;
      #1; tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_cycle_cnt0 got busy=%b exp 0", busy); end
   endtask

   task automatic test_spurious();
      do_reset();
      per_r_valid = 1'b1; per_r_id = 5'b00100;
      #1;
      n_vec++; if (r_valid !== 4'b0100) begin n_err++; $display("FAIL spurious_rv got %b exp 0100", r_valid); end
      tick();
      idle_inputs();
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL spurious_busy got %b exp 0", busy); end
      req = 4'b0100; per_gnt = 1'b1;
      for (int c = 0; c < MO; c++) begin
         #1;
         n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL spurious_cnt_fill[%0d] got %b exp 0100", c, gnt); end
         tick();
      end
      #1;
      n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL spurious_cnt_limit got %b exp 0000", gnt); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL spurious_busy_full got %b exp 1", busy); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy got %b exp 0", busy); end
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_atop();
      do_reset();
      req = 4'b0011; atop[0] = 6'h21; wen = 4'b0010; per_gnt = 1'b1;
      #1;
      n_vec++; if (gnt !== 4'b0001 || per_atop !== 6'h21) begin
         n_err++; $display("FAIL atop_first got gnt=%b atop=%h exp gnt=0001 atop=21", gnt, per_atop); end
      tick();
      atop[0] = 6'h00; req = 4'b0010;
      #1;
`ifdef PER2AXI_ARB_ATOP_SERIALIZE_EN
      n_vec++; if (per_req !== 1'b0 || gnt !== 4'b0000) begin
         n_err++; $display("FAIL atop_locked got req=%b gnt=%b exp req=0 gnt=0000", per_req, gnt); end
      tick();
      per_r_valid = 1'b1; per_r_id = 5'b00001;
      #1;
      n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL atop_resp_cycle got %b exp 0000", gnt); end
      tick();
      per_r_valid = 1'b0; per_r_id = '0;
      #1;
      n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL atop_release got %b exp 0010", gnt); end
`else
      n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL atop_no_lock got %b exp 0010", gnt); end
`endif
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         req     = 4'($urandom_range(0, 15));
         wen     = 4'($urandom_range(0, 15));
         per_gnt = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NB; i++) begin
            add[i]   = $urandom();
            wdata[i] = $urandom();
            be[i]    = 4'($urandom_range(0, 15));
            atop[i]  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         end
         per_r_valid = 1'b0; per_r_id = '0;
         per_r_rdata = $urandom(); per_r_opc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            int s;
            s = $urandom_range(0, NB - 1);
            for (int k = 0; k < NB; k++) begin
               int i;
               i = (s + k) % NB;
               if (!per_r_valid && m_cnt[i] > 0) begin
                  per_r_valid = 1'b1; per_r_id[i] = 1'b1;
               end
            end
         end
         #1;
         model_eval();
         n_vec++; if (per_req !== e_req) begin n_err++; $display("FAIL rnd_per_req[%0d] got %b exp %b", c, per_req, e_req); end
         n_vec++; if (gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b exp %b", c, gnt, e_gnt); end
         n_vec++; if (per_id !== e_id) begin n_err++; $display("FAIL rnd_id[%0d] got %b exp %b", c, per_id, e_id); end
         n_vec++; if (r_valid !== e_rv) begin n_err++; $display("FAIL rnd_r_valid[%0d] got %b exp %b", c, r_valid, e_rv); end
         n_vec++; if (r_rdata !== per_r_rdata || r_opc !== per_r_opc) begin
            n_err++; $display("FAIL rnd_rsp_data[%0d] got %h/%b exp %h/%b", c, r_rdata, r_opc, per_r_rdata, per_r_opc); end
         n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy[%0d] got %b exp %b", c, busy, m_busy); end
         if (e_req) begin
            n_vec++;
            if ({per_add, per_wen, per_wdata, per_be, per_atop} !==
                {add[e_w], wen[e_w], wdata[e_w], be[e_w], atop[e_w]}) begin
               n_err++; $display("FAIL rnd_fields[%0d] got %h %b %h %h %h exp %h %b %h %h %h", c,
                  per_add, per_wen, per_wdata, per_be, per_atop,
                  add[e_w], wen[e_w], wdata[e_w], be[e_w], atop[e_w]);
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_max_outst();
      test_same_cycle();
      test_spurious();
      test_atop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
